// File: rtl/ssd_scan_decoder_if.sv
// Pin-side inputs and decoded outputs of the seven-segment scan decoder.
// The master drives the display pins; the slave is the decoder.
interface ssd_scan_decoder_if;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
    logic [3:0] digit_blank;
    logic [3:0] digit_err;
    logic       frame_valid;
    logic       scan_lost;

    modport master (
        output seg_n, an_n,
        input  digit1, digit2, digit3, digit4, digit_blank, digit_err, frame_valid, scan_lost
    );

    modport slave (
        input  seg_n, an_n,
        output digit1, digit2, digit3, digit4, digit_blank, digit_err, frame_valid, scan_lost
    );
endinterface

// File: rtl/ssd_scan_decoder.sv
// Receive side of a 4-digit multiplexed seven-segment scan: synchronizes the pins,
// waits for a stable digit, decodes it back to BCD and reports complete frames.
module ssd_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 262144
) (
    input logic               clk,
    input logic               rst_n,
    ssd_scan_decoder_if.slave bus
);
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [TW-1:0] tcnt;
    logic [10:0]   sync1, sync2, prev;
    logic [3:0]    an_low, cap_an, dec_val, mask;
    logic [6:0]    cap_seg;
    logic          an_one, changed, capture, dec_blank, dec_err;
    logic [3:0]    d1, d2, d3, d4, blank_q, err_q;
    logic          fv_q, lost_q;

    // prev is the synced value one cycle older, so it holds the value that was stable
    // for the whole settle window even when the pins move on the capture edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {bus.an_n, bus.seg_n};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign an_low  = ~sync2[10:7];
    assign an_one  = (an_low != '0) && ((an_low & (an_low - 4'd1)) == '0);
    assign changed = (sync2 != prev);
    assign cap_an  = prev[10:7];
    assign cap_seg = prev[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (an_one) begin
                    state_n = SETTLE;
                    cnt_n   = CW'(1);
                end
            end
            SETTLE: begin
                capture = (cnt == CNT_CAP);
                if (changed) begin
                    if (an_one) begin
                        cnt_n = CW'(1);
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else if (capture) begin
                    state_n = CAPTURED;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            CAPTURED: begin
                if (changed) begin
                    if (an_one) begin
                        state_n = SETTLE;
                        cnt_n   = CW'(1);
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        dec_val   = 4'hE;
        case (cap_seg)
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            7'b1111111: begin
                dec_val   = 4'hF;
                dec_blank = 1'b1;
            end
            default:    dec_err = 1'b1;
        endcase
    end

    // Per-digit bit vectors share the anode ordering, so ~cap_an selects the bit directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1      <= 4'hF;
            d2      <= 4'hF;
            d3      <= 4'hF;
            d4      <= 4'hF;
            blank_q <= '1;
            err_q   <= '0;
            mask    <= '0;
            fv_q    <= 1'b0;
            lost_q  <= 1'b0;
            tcnt    <= '0;
        end else begin
            fv_q <= (mask == 4'hF);
            if (capture) begin
                if (!cap_an[3]) d1 <= dec_val;
                if (!cap_an[2]) d2 <= dec_val;
                if (!cap_an[1]) d3 <= dec_val;
                if (!cap_an[0]) d4 <= dec_val;
                blank_q <= (blank_q & cap_an) | (~cap_an & {4{dec_blank}});
                err_q   <= (err_q & cap_an) | (~cap_an & {4{dec_err}});
                mask    <= mask | ~cap_an;
                tcnt    <= '0;
                lost_q  <= 1'b0;
            end else begin
                if (tcnt != TO_MAX) tcnt <= tcnt + TW'(1);
                if (tcnt == TO_LAST) begin
                    lost_q <= 1'b1;
                    mask   <= '0;
                end else if (mask == 4'hF) begin
                    mask <= '0;
                end
            end
        end
    end

    assign bus.digit1      = d1;
    assign bus.digit2      = d2;
    assign bus.digit3      = d3;
    assign bus.digit4      = d4;
    assign bus.digit_blank = blank_q;
    assign bus.digit_err   = err_q;
    assign bus.frame_valid = fv_q;
    assign bus.scan_lost   = lost_q;
endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed vector table, corner sequences and random scans,
// all checked every cycle against a run-length reference model of the pin history.
module tb_ssd_scan_decoder;
    localparam int unsigned S = 16;
    localparam int unsigned T = 500;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ssd_scan_decoder_if bus();

    ssd_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int unsigned hold;
        logic [3:0]  val;
        logic        blank;
        logic        err;
    } vec_t;

    logic [6:0]  SEG [10];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned fv_seen = 0;

    logic [10:0] hist[$];
    logic [3:0]  m_digit [4];
    logic [3:0]  m_blank, m_err, m_mask;
    logic        m_fv, m_lost;
    int unsigned m_tcnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic int unsigned zeros(input logic [3:0] an);
        int unsigned z = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) z++;
        return z;
    endfunction

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < S + 4; i++) hist.push_back(11'h7FF);
        for (int i = 0; i < 4; i++) m_digit[i] = 4'hF;
        m_blank = 4'hF; m_err = '0; m_mask = '0; m_fv = 1'b0; m_lost = 1'b0; m_tcnt = 0;
    endtask

    // A digit is taken at edge t when the pin value seen at edge t-3 closes a run of
    // exactly S identical single-anode samples.
    task automatic model_step();
        logic [10:0] v;
        logic        cap, fv_new, bl, er;
        logic [3:0]  val;
        int unsigned idx;
        hist.push_front({bus.an_n, bus.seg_n});
        void'(hist.pop_back());
        v   = hist[3];
        cap = (zeros(v[10:7]) == 1);
        for (int k = 3; k < S + 3; k++) if (hist[k] != v) cap = 1'b0;
        if (hist[S + 3] == v) cap = 1'b0;
        fv_new = (m_mask == 4'hF);
        if (cap) begin
            val = 4'hE; bl = 1'b0; er = 1'b1;
            if (v[6:0] == 7'h7F) begin val = 4'hF; bl = 1'b1; er = 1'b0; end
            for (int d = 0; d < 10; d++) if (v[6:0] == SEG[d]) begin val = 4'(d); er = 1'b0; end
            idx = 0;
            for (int i = 0; i < 4; i++) if (!v[10 - i]) idx = i;
            m_digit[idx]     = val;
            m_blank[3 - idx] = bl;
            m_err[3 - idx]   = er;
            m_mask[3 - idx]  = 1'b1;
            m_tcnt = 0;
            m_lost = 1'b0;
        end else if (m_tcnt < T) begin
            m_tcnt++;
            if (m_tcnt == T) begin m_lost = 1'b1; m_mask = '0; end
        end
        if (fv_new) m_mask = '0;
        m_fv = fv_new;
    endtask

    task automatic compare();
        logic [25:0] got, exp;
        got = {bus.digit1, bus.digit2, bus.digit3, bus.digit4, bus.digit_blank, bus.digit_err,
               bus.frame_valid, bus.scan_lost};
        exp = {m_digit[0], m_digit[1], m_digit[2], m_digit[3], m_blank, m_err, m_fv, m_lost};
        check("model_outputs", 32'(got), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        #1;
        if (bus.frame_valid) fv_seen++;
        compare();
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int unsigned n);
        bus.an_n  = an;
        bus.seg_n = seg;
        repeat (n) tick();
    endtask

    function automatic logic [3:0] dut_digit(input int unsigned i);
        case (i)
            0: return bus.digit1;
            1: return bus.digit2;
            2: return bus.digit3;
            default: return bus.digit4;
        endcase
    endfunction

    initial begin
        vec_t        tbl [6];
        int unsigned idx, lat, fv0;
        logic        got;
        logic [3:0]  an;
        logic [6:0]  seg;

        SEG = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        tbl[0] = '{4'b0111, SEG[1], 40, 4'h1, 1'b0, 1'b0};
        tbl[1] = '{4'b1011, SEG[2], 40, 4'h2, 1'b0, 1'b0};
        tbl[2] = '{4'b1101, SEG[3], 40, 4'h3, 1'b0, 1'b0};
        tbl[3] = '{4'b1110, SEG[4], 40, 4'h4, 1'b0, 1'b0};
        tbl[4] = '{4'b1011, 7'b0101010, 40, 4'hE, 1'b0, 1'b1};
        tbl[5] = '{4'b1101, 7'b1111111, 40, 4'hF, 1'b1, 1'b0};

        bus.an_n = 4'hF;
        bus.seg_n = 7'h7F;
        model_reset();
        repeat (3) tick();
        check("reset_digits", {16'h0, bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 32'hFFFF);
        check("reset_blank", 32'(bus.digit_blank), 32'hF);
        check("reset_flags", {29'h0, bus.digit_err != 0, bus.frame_valid, bus.scan_lost}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Scan 1-2-3-4, then an illegal and a blank pattern.
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].an, tbl[i].seg, tbl[i].hold);
            idx = 0;
            for (int k = 0; k < 4; k++) if (!tbl[i].an[3 - k]) idx = k;
            check("table_value", 32'(dut_digit(idx)), 32'(tbl[i].val));
            check("table_blank_err", {30'h0, bus.digit_blank[3 - idx], bus.digit_err[3 - idx]},
                  {30'h0, tbl[i].blank, tbl[i].err});
            if (i == 3) begin
                check("one_frame_pulse", fv_seen, 1);
                check("scan_blank_all", 32'(bus.digit_blank), 32'h0);
            end
        end

        // One cycle short of the settle window, a glitch, then a full hold.
        drive(4'b1110, SEG[5], S - 1);
        drive(4'b1110, SEG[8], 3);
        check("short_hold_no_capture", 32'(bus.digit4), 32'h4);
        bus.seg_n = SEG[5];
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (!got && bus.digit4 == 4'h5) begin lat = i; got = 1'b1; end
        end
        check("settle_latency", lat, S + 3);

        // Multiple anodes: no capture, seen mask survives.
        drive(4'b0011, SEG[8], 100);
        check("multi_no_capture", {16'h0, bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 32'h1EF5);
        fv0 = fv_seen;
        drive(4'b0111, SEG[7], 40);
        check("mask_kept_frame", fv_seen - fv0, 1);

        drive(4'b1111, 7'h7F, T + 5);
        check("scan_lost_set", 32'(bus.scan_lost), 32'h1);
        check("digits_kept_on_loss", {16'h0, bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 32'h7EF5);
        drive(4'b1101, SEG[6], 25);
        check("scan_lost_clear", 32'(bus.scan_lost), 32'h0);
        check("recover_digit3", 32'(bus.digit3), 32'h6);

        // Asynchronous reset in the middle of a settle window.
        drive(4'b1011, SEG[9], 10);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare();
        check("async_reset_digits", {16'h0, bus.digit1, bus.digit2, bus.digit3, bus.digit4}, 32'hFFFF);
        repeat (2) tick();
        @(negedge clk) rst_n = 1'b1;
        repeat (10) tick();
        check("no_stale_capture", 32'(bus.digit2), 32'hF);

        // Random scan traffic.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                7: an = 4'hF;
                8, 9: begin
                    an = 4'($urandom_range(0, 15));
                    while (zeros(an) < 2) an = 4'($urandom_range(0, 15));
                end
                default: an = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 9))
                7: seg = 7'h7F;
                8, 9: seg = 7'($urandom_range(0, 127));
                default: seg = SEG[$urandom_range(0, 9)];
            endcase
            drive(an, seg, $urandom_range(1, S + 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
